if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch initiator for the instruction ROM.
- Holds the PC, drives ROM chip-enable and byte address, and captures the combinationally returned instruction word.
- Queues fetched {pc, inst} pairs in a small FIFO toward the decode stage with a valid/ready handshake.
- Supports branch/jump redirect with flush; sits between the PC/branch unit and ID.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded at reset (word-aligned).
- DEPTH, 2: FIFO entries, power of two, ≥2.
- PTR_W, 1: log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- rom_ce  output  1  ROM chip enable; 1 = fetch request this cycle.
- rom_addr  output  32  ROM byte address; always equal to the current PC.
- rom_inst  input  32  instruction word returned by ROM in the same cycle.
- redirect_i  input  1  branch/jump taken; flush and load target.
- redirect_pc_i  input  32  redirect target byte address.
- if_valid_o  output  1  head FIFO entry valid toward ID.
- if_ready_i  input  1  ID accepts the head entry this cycle.
- if_pc_o  output  32  PC of head entry.
- if_inst_o  output  32  instruction of head entry.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; rom_ce=0.
  - FIFO empty: rd/wr pointers and count = 0.
  - if_valid_o=0, if_pc_o=0, if_inst_o=0.
- rom_ce is a register: 0 during reset, 1 from the first rising edge after rst deasserts. Once 1, it stays 1 until the next reset.
- rom_addr is driven combinationally from pc. Its low 2 bits are always 00.
- pop = if_valid_o & if_ready_i.
- push = rom_ce & ~redirect_i & (count<DEPTH | pop).
  - When full, push is allowed in the same cycle as a pop. Count is unchanged.
- On push, the write entry gets {pc, rom_inst} and pc <= pc+4. Addition is modulo 2^32: pc 32'hFFFF_FFFC wraps to 0.
- When there is no push and no redirect, pc holds (stall). rom_ce remains 1 and rom_addr stays stable.
- Redirect (priority over everything):
  - On redirect_i=1 at an edge: FIFO flushed (count=0, pointers=0).
  - pc <= {redirect_pc_i[31:2], 2'b00}; misaligned low bits are dropped.
  - No push and no pop take effect that cycle, even if if_ready_i=1.
  - Next cycle: if_valid_o=0, and fetch resumes at the target.
- Outputs:
  - if_valid_o = (count!=0).
  - if_pc_o/if_inst_o are driven from the head entry when valid and are 0 when empty.
  - Combinational from FIFO registers only; no path from rom_inst to if_*_o.
- Latency: instruction at address A appears on if_*_o one cycle after the cycle rom_addr=A was pushed.
- Throughput: 1 instr/cycle when if_ready_i is held 1.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - Pop when empty is impossible (if_valid_o=0).
- Reset mid-operation: all state returns immediately to reset values regardless of clk. In-flight entries are lost.

Test Plan:
- Reset release, if_ready_i=1, ROM word n = 32'h1000_0000+n:
  - rom_ce=1 one edge after release; rom_addr 0,4,8.
  - if_valid_o=1 next cycle with pc=0, inst=32'h1000_0000, then one entry per cycle.
- Backpressure: if_ready_i=0 from the 1st valid cycle:
  - FIFO fills with pc 0 and 4; rom_addr holds at 8; count stays 2.
  - On if_ready_i=1, entries drain 0, 4, 8 in order with no gap and no duplicate.
- Redirect while full: redirect_i=1, redirect_pc_i=32'h0000_0103:
  - Next cycle if_valid_o=0 and rom_addr=32'h0000_0100.
  - The following cycle if_pc_o=32'h100; the old entries are never presented.
- Redirect with if_ready_i=1 and a valid head: head not consumed; no extra entry pushed that cycle.
- Wrap: redirect to 32'hFFFF_FFFC, if_ready_i=1 -> if_pc_o sequence FFFF_FFFC then 0000_0000.
- Async reset asserted mid-stream between clock edges:
  - if_valid_o and rom_ce drop to 0 immediately.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch initiator for the instruction ROM.
//
// Holds the program counter, requests one instruction per cycle from a
// combinational ROM, and queues the returned {pc, inst} pairs in a small
// FIFO toward the decode stage. A branch/jump redirect flushes the queue
// and restarts fetching at the (word-aligned) target.
//
// Ports
//   clk           : system clock, rising edge
//   rst           : asynchronous active-low reset
//   rom_ce        : ROM chip enable, 1 = fetch request this cycle
//   rom_addr      : ROM byte address, always the current PC
//   rom_inst      : instruction word returned by the ROM in the same cycle
//   redirect_i    : branch/jump taken; flush and load redirect_pc_i
//   redirect_pc_i : redirect target byte address (low 2 bits ignored)
//   if_valid_o    : head FIFO entry valid toward decode
//   if_ready_i    : decode accepts the head entry this cycle
//   if_pc_o       : PC of the head entry (0 when empty)
//   if_inst_o     : instruction of the head entry (0 when empty)
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int          PTR_W    = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [31:0]      pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic push;
  logic pop;

  assign rom_addr   = pc;
  assign if_valid_o = (count != '0);

  // A full FIFO still accepts a new entry when the head leaves this cycle.
  assign pop  = if_valid_o & if_ready_i;
  assign push = rom_ce & ~redirect_i & ((count < DEPTH_C) | pop);

  // Head is gated by valid so stale storage never leaks out when empty.
  assign if_pc_o   = if_valid_o ? pc_mem[rd_ptr]   : 32'h0;
  assign if_inst_o = if_valid_o ? inst_mem[rd_ptr] : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      rom_ce <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rom_ce <= 1'b1;
      if (redirect_i) begin
        // Redirect wins over everything: drop queued entries, ignore pop.
        pc     <= redirect_pc_i & 32'hFFFF_FFFC;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        unique case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; entries are only ever
  // observed through the reset pointers/count, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= rom_inst;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
//
// A transaction-level model (PC plus a queue of {pc, inst} pairs) tracks
// what the fetch unit must present; a compare process checks every output
// against it on each falling edge. Directed scenarios add hand-computed
// literal expectations, then a randomized phase mixes backpressure,
// redirects and asynchronous resets.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b1;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  int vectors = 0;
  int fails   = 0;

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH),
    .PTR_W    (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_pc_o       (if_pc_o),
    .if_inst_o     (if_inst_o)
  );

  always #5 clk = ~clk;

  // ROM word n (byte address 4n) holds 32'h1000_0000 + n.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  assign rom_inst = rom_word(rom_addr);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic        m_ce;
  entry_t      m_q[$];

  task automatic model_reset();
    m_pc = 32'h0;
    m_ce = 1'b0;
    m_q.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        automatic bit do_pop  = (m_q.size() != 0) && if_ready_i;
        automatic bit do_push = m_ce && (m_q.size() < DEPTH || do_pop);
        if (redirect_i) begin
          m_q.delete();
          m_pc = {redirect_pc_i[31:2], 2'b00};
        end else begin
          if (do_pop) void'(m_q.pop_front());
          if (do_push) begin
            m_q.push_back('{pc: m_pc, inst: rom_word(m_pc)});
            m_pc = m_pc + 32'd4;
          end
        end
        m_ce = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("rom_ce", {31'b0, rom_ce}, {31'b0, m_ce});
      check("rom_addr", rom_addr, m_pc);
      check("if_valid", {31'b0, if_valid_o}, {31'b0, m_q.size() != 0});
      check("if_pc", if_pc_o, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
      check("if_inst", if_inst_o, (m_q.size() != 0) ? m_q[0].inst : 32'h0);
    end
  end

  // Advance to just after the next rising edge; inputs change here.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state.
    #3;
    check("rst_ce", {31'b0, rom_ce}, 32'h0);
    check("rst_valid", {31'b0, if_valid_o}, 32'h0);
    check("rst_pc_o", if_pc_o, 32'h0);
    check("rst_inst_o", if_inst_o, 32'h0);
    check("rst_addr", rom_addr, 32'h0);
    cycle();
    rst = 1'b1;

    // Streaming with ready held high.
    cycle();
    check("s_ce", {31'b0, rom_ce}, 32'h1);
    check("s_addr0", rom_addr, 32'h0);
    check("s_valid0", {31'b0, if_valid_o}, 32'h0);
    cycle();
    check("s_valid1", {31'b0, if_valid_o}, 32'h1);
    check("s_pc1", if_pc_o, 32'h0);
    check("s_inst1", if_inst_o, 32'h1000_0000);
    check("s_addr1", rom_addr, 32'h4);
    cycle();
    check("s_pc2", if_pc_o, 32'h4);
    check("s_addr2", rom_addr, 32'h8);

    // Backpressure from the first valid cycle.
    do_reset();
    if_ready_i = 1'b0;
    cycle();
    cycle();
    check("bp_pc_a", if_pc_o, 32'h0);
    cycle();
    check("bp_addr_full", rom_addr, 32'h8);
    cycle();
    check("bp_addr_hold", rom_addr, 32'h8);
    check("bp_pc_hold", if_pc_o, 32'h0);
    if_ready_i = 1'b1;
    cycle();
    check("bp_drain4", if_pc_o, 32'h4);
    cycle();
    check("bp_drain8", if_pc_o, 32'h8);

    // Redirect while full.
    if_ready_i = 1'b0;
    cycle();
    cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    cycle();
    redirect_i = 1'b0;
    check("rd_valid", {31'b0, if_valid_o}, 32'h0);
    check("rd_addr", rom_addr, 32'h0000_0100);
    cycle();
    check("rd_pc", if_pc_o, 32'h0000_0100);
    check("rd_inst", if_inst_o, 32'h1000_0040);

    // Redirect with ready high and a valid head.
    if_ready_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    cycle();
    redirect_i = 1'b0;
    check("rr_valid", {31'b0, if_valid_o}, 32'h0);
    check("rr_addr", rom_addr, 32'h0000_0200);

    // PC wrap.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    redirect_i = 1'b0;
    cycle();
    check("wr_pc0", if_pc_o, 32'hFFFF_FFFC);
    check("wr_addr", rom_addr, 32'h0);
    cycle();
    check("wr_pc1", if_pc_o, 32'h0);

    // Asynchronous reset between edges.
    #1 rst = 1'b0;
    #1;
    check("ar_valid", {31'b0, if_valid_o}, 32'h0);
    check("ar_ce", {31'b0, rom_ce}, 32'h0);
    check("ar_addr", rom_addr, 32'h0);
    cycle();
    rst = 1'b1;
    cycle();
    cycle();
    check("ar_restart", if_pc_o, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if_ready_i    = ($urandom_range(0, 3) != 0);
      redirect_i    = ($urandom_range(0, 15) == 0);
      redirect_pc_i = $urandom();
      if ($urandom_range(0, 199) == 0) begin
        #($urandom_range(1, 2)) rst = 1'b0;
        cycle();
        rst = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
